control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit for the 32-bit CPU datapath: a step counter (T0..T7) plus opcode decode that drives every
//  datapath/memory strobe, replacing the hand-written bench sequences. Sits beside the datapath inside System and consumes IR and CON FF.
//  Executes fetch, ld/ldi/st, R-format ALU, immediate ALU, mul/div, in/out, nop, halt (+ optional branch).
// PARAMETERS
//  DATA_WIDTH  32  IR width; opcode = IR[31:27]
//  MEM_WAIT    0   extra cycles the memory-access steps (T1, ld T6, st T7) are held; 0..7
// PORTS
//  Clock               in  1   single clock, rising edge
//  clear               in  1   reset, asynchronous, active-low
//  ir                  in  32  instruction register contents
//  con_ff_bit          in  1   branch condition flip-flop
//  stop                in  1   halt request, sampled only at T0
//  run                 out 1   1 while executing, 0 in RST/HALT
//  PCout,Zhi_out,Zlo_out,MDRout,HIout,LOout,Inport_out,Cout  out 1 each  bus drive selects
//  MARin,Zin,PCin,MDRin,IRin,Yin,HIin,LOin,CONin,outport_in  out 1 each  register loads
//  Gra,Grb,Grc,Rin,Rout,BAout  out 1 each  register-file select/enable
//  IncPC               out 1   ALU passes B+1
//  opcode              out 5   ALU operation (ALU_ADD=00011 for address calc, else IR[31:27])
//  Mem_Read,Mem_Write,Mem_enable512x32  out 1 each  memory strobes
// BEHAVIOUR
//  - clear low: state=RST immediately; every output 0 (opcode=0, run=0). RST -> T0 on first edge after release.
//  - Outputs combinational from (step, IR[31:27], con_ff_bit); IR stable from T3 on. Unlisted outputs 0 in each step.
//  - Fetch: T0 PCout,IncPC,MARin,Zin | T1 Zlo_out,PCin,MDRin,Mem_Read,Mem_enable512x32 | T2 MDRout,IRin.
//  - R-ALU (00011..01011): T3 Grb,Rout,Yin | T4 Grc,Rout,opcode=IR,Zin | T5 Zlo_out,Gra,Rin. End.
//  - mul 01111/div 10000: T3 Gra,Rout,Yin | T4 Grb,Rout,opcode,Zin | T5 Zlo_out,LOin | T6 Zhi_out,HIin. End.
//  - Imm addi 01100/andi 01101/ori 01110: T3 Grb,Rout,Yin | T4 Cout,opcode=IR,Zin | T5 Zlo_out,Gra,Rin.
//  - ldi 00001: as Imm with BAout instead of Rout, opcode=ALU_ADD.
//  - ld 00000: T3 Grb,BAout,Yin | T4 Cout,ALU_ADD,Zin | T5 Zlo_out,MARin | T6 Mem_Read,Mem_enable512x32,MDRin | T7 MDRout,Gra,Rin.
//  - st 00010: T3..T5 as ld | T6 Gra,Rout,MDRin | T7 Mem_Write,Mem_enable512x32.
//  - in 10110: T3 Inport_out,Gra,Rin. out 10111: T3 Gra,Rout,outport_in. nop 11010 / undefined opcode: T3 all-zero.
//  - halt 11011: T3 -> HALT. HALT sticky, all outputs 0, run=0; exit only via clear.
//  - End step of each instruction -> T0 next edge; no idle cycle between instructions.
//  - Memory steps held MEM_WAIT+1 cycles (wait counter); all outputs of that step held (loads idempotent).
//  - stop=1 at T0: T0 outputs suppressed, go HALT. stop ignored in other steps (instruction completes).
//  - Reset mid-instruction: abort, outputs 0 same instant, restart fetch at T0 after RST.
// CONFIGURATION
//  BRANCH_EN defined: br 10010 = T3 Gra,Rout,CONin | T4 PCout,Yin | T5 Cout,ALU_ADD,Zin | T6 Zlo_out,PCin only if con_ff_bit=1, else zeros.
//  BRANCH_EN undefined: 10010 decoded as nop (ends at T3, no CONin/PCin).
// STRUCTURE
//  Package ctrl_pkg: opcode constants (OP_LD..OP_HALT), ALU_ADD, step encoding (RST,T0..T7,HALT).
//  Sub-module control_decode: pure combinational (step, op, con_ff_bit) -> strobe vector; control_sequencer keeps step/wait regs.
// TESTING
//  1 clear low mid-T4 of add -> all outputs 0 same cycle; after release RST, then T0 with PCout=IncPC=MARin=Zin=1.
//  2 mem[0]=in r3 (0xB1800000), mem[1]=out r3 (0xB9800000), inport=0x55 -> outport_data=0x55 at end of 8th post-T0 cycle.
//  3 add r1,r2,r3 with r2=5,r3=7 -> T4 opcode=00011, r1=12 after T5; next fetch at the following cycle.
//  4 st 0x20(r2), r2=0x10, then ld r4 from same address -> mem[0x30]=r_a, r4 equals it; MEM_WAIT=2 -> T6/T7 memory strobes held 3 cycles.
//  5 stop=1 at T0 -> HALT, run=0, no further strobes for 20 cycles; halt opcode gives same result after T3.
//  6 BRANCH_EN: brzr r1 with r1=0 -> PCin at T6, PC=PC+1+C; r1=1 -> no PCin. Without macro -> ends at T3.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the hardwired control unit.
// Opcode constants, ALU_ADD, step encoding, strobe record and instruction classing.
// Optional feature macro: BRANCH_EN (enables the br 10010 instruction; otherwise it is a nop).
package ctrl_pkg;

   localparam logic [4:0] OP_LD    = 5'b00000;
   localparam logic [4:0] OP_LDI   = 5'b00001;
   localparam logic [4:0] OP_ST    = 5'b00010;
   localparam logic [4:0] OP_ADD   = 5'b00011;
   localparam logic [4:0] OP_RLAST = 5'b01011;
   localparam logic [4:0] OP_ADDI  = 5'b01100;
   localparam logic [4:0] OP_ANDI  = 5'b01101;
   localparam logic [4:0] OP_ORI   = 5'b01110;
   localparam logic [4:0] OP_MUL   = 5'b01111;
   localparam logic [4:0] OP_DIV   = 5'b10000;
   localparam logic [4:0] OP_BR    = 5'b10010;
   localparam logic [4:0] OP_IN    = 5'b10110;
   localparam logic [4:0] OP_OUT   = 5'b10111;
   localparam logic [4:0] OP_NOP   = 5'b11010;
   localparam logic [4:0] OP_HALT  = 5'b11011;

   // ALU operation used for every address or offset calculation
   localparam logic [4:0] ALU_ADD  = 5'b00011;

   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_T7   = 4'd8,
      ST_HALT = 4'd9
   } step_t;

   typedef enum logic [3:0] {
      CL_NOP, CL_RALU, CL_MULDIV, CL_IMM, CL_LDI, CL_LD, CL_ST,
      CL_IN, CL_OUT, CL_HALT, CL_BR
   } iclass_t;

   typedef struct packed {
      logic       PCout;
      logic       Zhi_out;
      logic       Zlo_out;
      logic       MDRout;
      logic       HIout;
      logic       LOout;
      logic       Inport_out;
      logic       Cout;
      logic       MARin;
      logic       Zin;
      logic       PCin;
      logic       MDRin;
      logic       IRin;
      logic       Yin;
      logic       HIin;
      logic       LOin;
      logic       CONin;
      logic       outport_in;
      logic       Gra;
      logic       Grb;
      logic       Grc;
      logic       Rin;
      logic       Rout;
      logic       BAout;
      logic       IncPC;
      logic [4:0] opcode;
      logic       Mem_Read;
      logic       Mem_Write;
      logic       Mem_enable512x32;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // Groups opcodes that share a step sequence; unknown opcodes behave as nop
   function automatic iclass_t classify(input logic [4:0] op);
      iclass_t c;
      c = CL_NOP;
      if (op >= OP_ADD && op <= OP_RLAST) c = CL_RALU;
      else begin
         case (op)
            OP_LD:                    c = CL_LD;
            OP_LDI:                   c = CL_LDI;
            OP_ST:                    c = CL_ST;
            OP_ADDI, OP_ANDI, OP_ORI: c = CL_IMM;
            OP_MUL, OP_DIV:           c = CL_MULDIV;
            OP_IN:                    c = CL_IN;
            OP_OUT:                   c = CL_OUT;
            OP_HALT:                  c = CL_HALT;
`ifdef BRANCH_EN
            OP_BR:                    c = CL_BR;
`endif
            default:                  c = CL_NOP;
         endcase
      end
      return c;
   endfunction

   // Final execute step of each instruction class; the step after it is the next fetch
   function automatic step_t last_step(input iclass_t c);
      step_t s;
      case (c)
         CL_RALU, CL_IMM, CL_LDI: s = ST_T5;
         CL_MULDIV, CL_BR:        s = ST_T6;
         CL_LD, CL_ST:            s = ST_T7;
         default:                 s = ST_T3;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: purely combinational map from (step, opcode, con_ff_bit) to the datapath strobe vector.
// Steps without a listed action, RST and HALT all produce an all-zero vector.
module control_decode
   import ctrl_pkg::*;
(
   input  logic [3:0]        step,
   input  logic [4:0]        op,
   input  logic              con_ff_bit,
   output logic [CTRL_W-1:0] strobes
);

   step_t   s;
   iclass_t cls;
   ctrl_t   c;

   assign s       = step_t'(step);
   assign cls     = classify(op);
   assign strobes = c;

   // Strobe table: fetch steps are common, execute steps depend on the instruction class
   always_comb begin
      c = '0;
      case (s)
         ST_T0: begin
            c.PCout = 1'b1; c.IncPC = 1'b1; c.MARin = 1'b1; c.Zin = 1'b1;
         end
         ST_T1: begin
            c.Zlo_out = 1'b1; c.PCin = 1'b1; c.MDRin = 1'b1;
            c.Mem_Read = 1'b1; c.Mem_enable512x32 = 1'b1;
         end
         ST_T2: begin
            c.MDRout = 1'b1; c.IRin = 1'b1;
         end
         ST_T3: begin
            case (cls)
               CL_RALU, CL_IMM: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
               CL_MULDIV:       begin c.Gra = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
               CL_LDI, CL_LD, CL_ST: begin c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; end
               CL_IN:           begin c.Inport_out = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
               CL_OUT:          begin c.Gra = 1'b1; c.Rout = 1'b1; c.outport_in = 1'b1; end
               CL_BR:           begin c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1; end
               default: ;
            endcase
         end
         ST_T4: begin
            case (cls)
               CL_RALU:   begin c.Grc = 1'b1; c.Rout = 1'b1; c.opcode = op; c.Zin = 1'b1; end
               CL_MULDIV: begin c.Grb = 1'b1; c.Rout = 1'b1; c.opcode = op; c.Zin = 1'b1; end
               CL_IMM:    begin c.Cout = 1'b1; c.opcode = op; c.Zin = 1'b1; end
               CL_LDI, CL_LD, CL_ST: begin c.Cout = 1'b1; c.opcode = ALU_ADD; c.Zin = 1'b1; end
               CL_BR:     begin c.PCout = 1'b1; c.Yin = 1'b1; end
               default: ;
            endcase
         end
         ST_T5: begin
            case (cls)
               CL_RALU, CL_IMM, CL_LDI: begin c.Zlo_out = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
               CL_MULDIV:    begin c.Zlo_out = 1'b1; c.LOin = 1'b1; end
               CL_LD, CL_ST: begin c.Zlo_out = 1'b1; c.MARin = 1'b1; end
               CL_BR:        begin c.Cout = 1'b1; c.opcode = ALU_ADD; c.Zin = 1'b1; end
               default: ;
            endcase
         end
         ST_T6: begin
            case (cls)
               CL_MULDIV: begin c.Zhi_out = 1'b1; c.HIin = 1'b1; end
               CL_LD:     begin c.Mem_Read = 1'b1; c.Mem_enable512x32 = 1'b1; c.MDRin = 1'b1; end
               CL_ST:     begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1; end
               CL_BR:     begin c.Zlo_out = con_ff_bit; c.PCin = con_ff_bit; end
               default: ;
            endcase
         end
         ST_T7: begin
            case (cls)
               CL_LD: begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
               CL_ST: begin c.Mem_Write = 1'b1; c.Mem_enable512x32 = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the 32-bit datapath.
// Keeps the step counter (RST, T0..T7, HALT) and the memory wait counter; strobes come from control_decode.
// Optional feature macro: BRANCH_EN (br 10010 executes; otherwise decoded as nop).
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WAIT   = 0
)(
   input  logic                  Clock,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] ir,
   input  logic                  con_ff_bit,
   input  logic                  stop,
   output logic                  run,
   output logic                  PCout,
   output logic                  Zhi_out,
   output logic                  Zlo_out,
   output logic                  MDRout,
   output logic                  HIout,
   output logic                  LOout,
   output logic                  Inport_out,
   output logic                  Cout,
   output logic                  MARin,
   output logic                  Zin,
   output logic                  PCin,
   output logic                  MDRin,
   output logic                  IRin,
   output logic                  Yin,
   output logic                  HIin,
   output logic                  LOin,
   output logic                  CONin,
   output logic                  outport_in,
   output logic                  Gra,
   output logic                  Grb,
   output logic                  Grc,
   output logic                  Rin,
   output logic                  Rout,
   output logic                  BAout,
   output logic                  IncPC,
   output logic [4:0]            opcode,
   output logic                  Mem_Read,
   output logic                  Mem_Write,
   output logic                  Mem_enable512x32
);

   localparam logic [2:0] WAIT_MAX = 3'(MEM_WAIT);

   step_t             step, step_nxt;
   logic [2:0]        wait_cnt, wait_nxt;
   logic [4:0]        ir_op;
   iclass_t           cls;
   logic              mem_step, hold, blank;
   logic [CTRL_W-1:0] strobes;
   ctrl_t             dec, ctrl;
   logic              unused_ir;

   assign ir_op     = ir[DATA_WIDTH-1 -: 5];
   assign unused_ir = ^ir[DATA_WIDTH-6:0];
   assign cls       = classify(ir_op);

   // Memory-access steps are stretched by MEM_WAIT extra cycles with their strobes held
   assign mem_step = (step == ST_T1) ||
                     (step == ST_T6 && cls == CL_LD) ||
                     (step == ST_T7 && cls == CL_ST);
   assign hold     = mem_step && (wait_cnt != WAIT_MAX);

   control_decode u_decode (
      .step       (step),
      .op         (ir_op),
      .con_ff_bit (con_ff_bit),
      .strobes    (strobes)
   );

   // A halt request at T0 suppresses the fetch strobes in the same cycle it is seen
   assign blank = (step == ST_T0) && stop;
   assign dec   = ctrl_t'(strobes);
   assign ctrl  = blank ? '0 : dec;
   assign run   = (step != ST_RST) && (step != ST_HALT);

   assign PCout            = ctrl.PCout;
   assign Zhi_out          = ctrl.Zhi_out;
   assign Zlo_out          = ctrl.Zlo_out;
   assign MDRout           = ctrl.MDRout;
   assign HIout            = ctrl.HIout;
   assign LOout            = ctrl.LOout;
   assign Inport_out       = ctrl.Inport_out;
   assign Cout             = ctrl.Cout;
   assign MARin            = ctrl.MARin;
   assign Zin              = ctrl.Zin;
   assign PCin             = ctrl.PCin;
   assign MDRin            = ctrl.MDRin;
   assign IRin             = ctrl.IRin;
   assign Yin              = ctrl.Yin;
   assign HIin             = ctrl.HIin;
   assign LOin             = ctrl.LOin;
   assign CONin            = ctrl.CONin;
   assign outport_in       = ctrl.outport_in;
   assign Gra              = ctrl.Gra;
   assign Grb              = ctrl.Grb;
   assign Grc              = ctrl.Grc;
   assign Rin              = ctrl.Rin;
   assign Rout             = ctrl.Rout;
   assign BAout            = ctrl.BAout;
   assign IncPC            = ctrl.IncPC;
   assign opcode           = ctrl.opcode;
   assign Mem_Read         = ctrl.Mem_Read;
   assign Mem_Write        = ctrl.Mem_Write;
   assign Mem_enable512x32 = ctrl.Mem_enable512x32;

   // Next-step selection: hold memory steps, end each instruction straight into the next fetch
   always_comb begin
      step_nxt = step;
      wait_nxt = '0;
      case (step)
         ST_RST:  step_nxt = ST_T0;
         ST_HALT: step_nxt = ST_HALT;
         ST_T0:   step_nxt = stop ? ST_HALT : ST_T1;
         default: begin
            if (hold) begin
               step_nxt = step;
               wait_nxt = 3'(wait_cnt + 3'd1);
            end else if (step == ST_T3 && cls == CL_HALT) begin
               step_nxt = ST_HALT;
            end else if (step == last_step(cls)) begin
               step_nxt = ST_T0;
            end else begin
               step_nxt = step_t'(4'(step) + 4'd1);
            end
         end
      endcase
   end

   // Step and wait registers; clear aborts any instruction at once
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         step     <= ST_RST;
         wait_cnt <= '0;
      end else begin
         step     <= step_nxt;
         wait_cnt <= wait_nxt;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer (MEM_WAIT=2).
// Honours BRANCH_EN for the branch expectations.
module tb_control_sequencer;

   localparam int MEM_WAIT = 2;

   localparam logic [33:0] M_RUN   = 34'd1 << 33;
   localparam logic [33:0] M_PCO   = 34'd1 << 32;
   localparam logic [33:0] M_ZHI   = 34'd1 << 31;
   localparam logic [33:0] M_ZLO   = 34'd1 << 30;
   localparam logic [33:0] M_MDRO  = 34'd1 << 29;
   localparam logic [33:0] M_INP   = 34'd1 << 26;
   localparam logic [33:0] M_COUT  = 34'd1 << 25;
   localparam logic [33:0] M_MARI  = 34'd1 << 24;
   localparam logic [33:0] M_ZIN   = 34'd1 << 23;
   localparam logic [33:0] M_PCI   = 34'd1 << 22;
   localparam logic [33:0] M_MDRI  = 34'd1 << 21;
   localparam logic [33:0] M_IRI   = 34'd1 << 20;
   localparam logic [33:0] M_YIN   = 34'd1 << 19;
   localparam logic [33:0] M_HII   = 34'd1 << 18;
   localparam logic [33:0] M_LOI   = 34'd1 << 17;
   localparam logic [33:0] M_CONI  = 34'd1 << 16;
   localparam logic [33:0] M_OUTP  = 34'd1 << 15;
   localparam logic [33:0] M_GRA   = 34'd1 << 14;
   localparam logic [33:0] M_GRB   = 34'd1 << 13;
   localparam logic [33:0] M_GRC   = 34'd1 << 12;
   localparam logic [33:0] M_RIN   = 34'd1 << 11;
   localparam logic [33:0] M_ROUT  = 34'd1 << 10;
   localparam logic [33:0] M_BAO   = 34'd1 << 9;
   localparam logic [33:0] M_INC   = 34'd1 << 8;
   localparam logic [33:0] M_MRD   = 34'd1 << 2;
   localparam logic [33:0] M_MWR   = 34'd1 << 1;
   localparam logic [33:0] M_MEN   = 34'd1;

   localparam logic [33:0] F0 = M_RUN | M_PCO | M_INC | M_MARI | M_ZIN;
   localparam logic [33:0] F1 = M_RUN | M_ZLO | M_PCI | M_MDRI | M_MRD | M_MEN;
   localparam logic [33:0] F2 = M_RUN | M_MDRO | M_IRI;

   logic        Clock;
   logic        clear;
   logic [31:0] ir;
   logic        conFf;
   logic        stop;
   logic        run, PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out, Cout;
   logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
   logic        Gra, Grb, Grc, Rin, Rout, BAout, IncPC;
   logic [4:0]  opcode;
   logic        Mem_Read, Mem_Write, Mem_enable512x32;
   logic [33:0] obs;
   int          checkCount;
   int          errorCount;

   control_sequencer #(.DATA_WIDTH(32), .MEM_WAIT(MEM_WAIT)) dut (
      .Clock(Clock), .clear(clear), .ir(ir), .con_ff_bit(conFf), .stop(stop), .run(run),
      .PCout(PCout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .MDRout(MDRout), .HIout(HIout),
      .LOout(LOout), .Inport_out(Inport_out), .Cout(Cout), .MARin(MARin), .Zin(Zin),
      .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
      .CONin(CONin), .outport_in(outport_in), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
      .Rout(Rout), .BAout(BAout), .IncPC(IncPC), .opcode(opcode), .Mem_Read(Mem_Read),
      .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32)
   );

   assign obs = {run, PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out, Cout,
                 MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
                 Gra, Grb, Grc, Rin, Rout, BAout, IncPC, opcode,
                 Mem_Read, Mem_Write, Mem_enable512x32};

   // Free-running 10-unit clock
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   function automatic logic [33:0] opc(input logic [4:0] o);
      return {26'd0, o, 3'd0};
   endfunction

   function automatic logic [31:0] mk(input logic [4:0] o);
      return {o, 27'h0123456};
   endfunction

   task automatic checkOutput(input string tag, input logic [33:0] got, input logic [33:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One cycle: sample at the falling edge, away from the active rising edge
   task automatic expectStep(input string tag, input logic [33:0] exp);
      @(negedge Clock);
      checkOutput(tag, obs, exp);
   endtask

   // Fetch of a new instruction; IR takes its new value once T0 has been checked
   task automatic applyStimulus(input logic [31:0] newIr);
      expectStep("T0", F0);
      ir = newIr;
      for (int i = 0; i <= MEM_WAIT; i++) expectStep("T1", F1);
      expectStep("T2", F2);
   endtask

   // Directed instruction sequence with hand-derived strobe vectors
   initial begin
      checkCount = 0;
      errorCount = 0;
      clear = 1'b0;
      stop  = 1'b0;
      conFf = 1'b0;
      ir    = mk(5'b00011);

      expectStep("reset", 34'd0);
      clear = 1'b1;

      applyStimulus(mk(5'b00011));
      expectStep("addT3", M_RUN | M_GRB | M_ROUT | M_YIN);
      expectStep("addT4", M_RUN | M_GRC | M_ROUT | opc(5'b00011) | M_ZIN);
      expectStep("addT5", M_RUN | M_ZLO | M_GRA | M_RIN);

      applyStimulus(mk(5'b00100));
      expectStep("subT3", M_RUN | M_GRB | M_ROUT | M_YIN);
      expectStep("subT4", M_RUN | M_GRC | M_ROUT | opc(5'b00100) | M_ZIN);
      clear = 1'b0;
      #1 checkOutput("abort", obs, 34'd0);
      expectStep("rstHold", 34'd0);
      clear = 1'b1;

      applyStimulus(32'hB1800000);
      expectStep("inT3", M_RUN | M_INP | M_GRA | M_RIN);
      applyStimulus(32'hB9800000);
      expectStep("outT3", M_RUN | M_GRA | M_ROUT | M_OUTP);

      applyStimulus(mk(5'b00010));
      expectStep("stT3", M_RUN | M_GRB | M_BAO | M_YIN);
      expectStep("stT4", M_RUN | M_COUT | opc(5'b00011) | M_ZIN);
      expectStep("stT5", M_RUN | M_ZLO | M_MARI);
      expectStep("stT6", M_RUN | M_GRA | M_ROUT | M_MDRI);
      for (int i = 0; i <= MEM_WAIT; i++) expectStep("stT7", M_RUN | M_MWR | M_MEN);

      applyStimulus(mk(5'b00000));
      expectStep("ldT3", M_RUN | M_GRB | M_BAO | M_YIN);
      expectStep("ldT4", M_RUN | M_COUT | opc(5'b00011) | M_ZIN);
      expectStep("ldT5", M_RUN | M_ZLO | M_MARI);
      for (int i = 0; i <= MEM_WAIT; i++) expectStep("ldT6", M_RUN | M_MRD | M_MEN | M_MDRI);
      expectStep("ldT7", M_RUN | M_MDRO | M_GRA | M_RIN);

      applyStimulus(mk(5'b01111));
      expectStep("mulT3", M_RUN | M_GRA | M_ROUT | M_YIN);
      expectStep("mulT4", M_RUN | M_GRB | M_ROUT | opc(5'b01111) | M_ZIN);
      stop = 1'b1;
      expectStep("mulT5", M_RUN | M_ZLO | M_LOI);
      expectStep("mulT6", M_RUN | M_ZHI | M_HII);
      stop = 1'b0;

      applyStimulus(mk(5'b01101));
      expectStep("andiT3", M_RUN | M_GRB | M_ROUT | M_YIN);
      expectStep("andiT4", M_RUN | M_COUT | opc(5'b01101) | M_ZIN);
      expectStep("andiT5", M_RUN | M_ZLO | M_GRA | M_RIN);

      applyStimulus(mk(5'b00001));
      expectStep("ldiT3", M_RUN | M_GRB | M_BAO | M_YIN);
      expectStep("ldiT4", M_RUN | M_COUT | opc(5'b00011) | M_ZIN);
      expectStep("ldiT5", M_RUN | M_ZLO | M_GRA | M_RIN);

      applyStimulus(mk(5'b11010));
      expectStep("nopT3", M_RUN);
      applyStimulus(mk(5'b11100));
      expectStep("undefT3", M_RUN);

`ifdef BRANCH_EN
      conFf = 1'b1;
      applyStimulus(mk(5'b10010));
      expectStep("brT3", M_RUN | M_GRA | M_ROUT | M_CONI);
      expectStep("brT4", M_RUN | M_PCO | M_YIN);
      expectStep("brT5", M_RUN | M_COUT | opc(5'b00011) | M_ZIN);
      expectStep("brT6", M_RUN | M_ZLO | M_PCI);
      conFf = 1'b0;
      applyStimulus(mk(5'b10010));
      expectStep("brnT3", M_RUN | M_GRA | M_ROUT | M_CONI);
      expectStep("brnT4", M_RUN | M_PCO | M_YIN);
      expectStep("brnT5", M_RUN | M_COUT | opc(5'b00011) | M_ZIN);
      expectStep("brnT6", M_RUN);
`else
      conFf = 1'b1;
      applyStimulus(mk(5'b10010));
      expectStep("brT3", M_RUN);
`endif

      stop = 1'b1;
      expectStep("stopT0", M_RUN);
      for (int i = 0; i < 20; i++) expectStep("haltStop", 34'd0);
      stop = 1'b0;
      expectStep("haltSticky", 34'd0);

      clear = 1'b0;
      expectStep("rst2", 34'd0);
      clear = 1'b1;
      applyStimulus(mk(5'b11011));
      expectStep("haltT3", M_RUN);
      for (int i = 0; i < 5; i++) expectStep("haltOp", 34'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
